// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : can_pkg
//  Description : Shared CAN encodings: error states, fault-confinement FSM
//                states, bus levels and frame-field codes for the monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

    typedef enum logic [1:0] {
        ERR_ACTIVE  = 2'd0,
        ERR_PASSIVE = 2'd1,
        ERR_BUSOFF  = 2'd2
    } err_state_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLAG   = 3'd1,
        ST_DWAIT  = 3'd2,
        ST_DELIM  = 3'd3,
        ST_BUSOFF = 3'd4
    } fc_state_e;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    localparam logic [4:0] FIELD_EOF       = 5'd5;
    localparam logic [4:0] FIELD_SRR       = 5'd8;
    localparam logic [4:0] FIELD_CRC_DELIM = 5'd17;
    localparam logic [4:0] FIELD_ACK_DELIM = 5'd18;

    // TEC never exceeds 256, so bit 8 alone flags bus-off.
    function automatic err_state_e decode_err_state(
        input logic [8:0]  tec,
        input logic [7:0]  rec,
        input logic [31:0] passive_lim
    );
        if (tec[8]) begin
            return ERR_BUSOFF;
        end
        if (({23'd0, tec} >= passive_lim) || ({24'd0, rec} >= passive_lim)) begin
            return ERR_PASSIVE;
        end
        return ERR_ACTIVE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_busoff_recovery.sv
`default_nettype none
// ============================================================================
//  Module      : can_busoff_recovery
//  Description : Counts 11-recessive-bit sequences while bus-off and pulses
//                o_recover_done when the required number has been seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_busoff_recovery
    import can_pkg::*;
#(
    parameter int RECOV_SEQS = 128
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_enable,
    input  logic i_sample_point,
    input  logic i_Data,
    output logic o_recover_done
);

    localparam logic [3:0] c_RUN_LAST = 4'd10;
    localparam logic [7:0] c_SEQ_LAST = 8'(RECOV_SEQS - 1);

    logic [3:0] run_q, run_d;
    logic [7:0] seq_q, seq_d;

    always_comb begin
        run_d          = run_q;
        seq_d          = seq_q;
        o_recover_done = 1'b0;
        if (!i_enable) begin
            run_d = 4'd0;
            seq_d = 8'd0;
        end else if (i_sample_point) begin
            if (i_Data == CAN_RECESSIVE) begin
                if (run_q == c_RUN_LAST) begin
                    run_d = 4'd0;
                    if (seq_q == c_SEQ_LAST) begin
                        seq_d          = 8'd0;
                        o_recover_done = 1'b1;
                    end else begin
                        seq_d = seq_q + 8'd1;
                    end
                end else begin
                    run_d = run_q + 4'd1;
                end
            end else begin
                run_d = 4'd0;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            run_q <= 4'd0;
            seq_q <= 8'd0;
        end else begin
            run_q <= run_d;
            seq_q <= seq_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_fault_confinement.sv
`default_nettype none
// ============================================================================
//  Module      : can_fault_confinement
//  Description : CAN TEC/REC bookkeeping, error-state decode and error-frame
//                sequencing (flag, delimiter) with bus-off recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_fault_confinement
    import can_pkg::*;
#(
    parameter int ERR_FLAG_BITS  = 6,
    parameter int ERR_DELIM_BITS = 8,
    parameter int TX_ERR_INC     = 8,
    parameter int PASSIVE_LIM    = 128,
    parameter int REC_RESYNC     = 120,
    parameter int RECOV_SEQS     = 128
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_sample_point,
    input  logic       i_Data,
    input  logic       i_tx_mode,
    input  logic       i_form_error,
    input  logic       i_bit_error,
    input  logic       i_stuff_error,
    input  logic       i_crc_error,
    input  logic       i_ack_error,
    input  logic       i_frame_ok,
    output logic [8:0] o_tec,
    output logic [7:0] o_rec,
    output logic [1:0] o_err_state,
    output logic       o_err_frame,
    output logic       o_tx_bit
);

    localparam int c_CNT_MAX = (ERR_FLAG_BITS > ERR_DELIM_BITS) ? ERR_FLAG_BITS : ERR_DELIM_BITS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_FLAG_END  = c_CNT_W'(ERR_FLAG_BITS);
    localparam logic [c_CNT_W-1:0] c_DELIM_END = c_CNT_W'(ERR_DELIM_BITS);
    localparam logic [9:0]         c_TEC_INC   = 10'(TX_ERR_INC);
    localparam logic [7:0]         c_REC_LOAD  = 8'(REC_RESYNC);

    fc_state_e           state_q, state_d;
    err_state_e          err_state_q, err_state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [8:0]          tec_q, tec_d;
    logic [7:0]          rec_q, rec_d;
    logic                flag_passive_q, flag_passive_d;
    logic                err_frame_q, err_frame_d;
    logic                tx_bit_q, tx_bit_d;

    logic                w_err_any;
    logic                w_recover_done;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic [9:0]          w_tec_add;
    logic [8:0]          w_tec_err;
    logic [7:0]          w_rec_err;

    assign w_err_any = i_form_error | i_bit_error | i_stuff_error | i_crc_error | i_ack_error;
    assign w_cnt_inc = cnt_q + c_CNT_W'(1);

    // TEC saturates at 256 so that bus-off is always exactly bit 8.
    assign w_tec_add = {1'b0, tec_q} + c_TEC_INC;
    assign w_tec_err = (w_tec_add >= 10'd256) ? 9'd256 : w_tec_add[8:0];
    assign w_rec_err = (rec_q == 8'hFF) ? 8'hFF : rec_q + 8'd1;

    can_busoff_recovery #(
        .RECOV_SEQS (RECOV_SEQS)
    ) u_busoff_recovery (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_enable       (state_q == ST_BUSOFF),
        .i_sample_point (i_sample_point),
        .i_Data         (i_Data),
        .o_recover_done (w_recover_done)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tec_d          = tec_q;
        rec_d          = rec_q;
        flag_passive_d = flag_passive_q;

        if (i_sample_point) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_err_any) begin
                        if (i_tx_mode) begin
                            tec_d = w_tec_err;
                        end else begin
                            rec_d = w_rec_err;
                        end
                        state_d        = ST_FLAG;
                        cnt_d          = '0;
                        flag_passive_d = (err_state_q != ERR_ACTIVE);
                    end else if (i_frame_ok) begin
                        if (i_tx_mode) begin
                            if (tec_q != 9'd0) begin
                                tec_d = tec_q - 9'd1;
                            end
                        end else if (rec_q > 8'd127) begin
                            rec_d = c_REC_LOAD;
                        end else if (rec_q != 8'd0) begin
                            rec_d = rec_q - 8'd1;
                        end
                    end
                end

                ST_FLAG: begin
                    // Only a transmitter's own bit error on an active flag is counted.
                    if (i_tx_mode && i_bit_error && !flag_passive_q) begin
                        tec_d = w_tec_err;
                    end
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_FLAG_END) begin
                        state_d = ST_DWAIT;
                    end
                end

                ST_DWAIT: begin
                    if (i_Data == CAN_RECESSIVE) begin
                        state_d = ST_DELIM;
                        cnt_d   = c_CNT_W'(1);
                    end
                end

                ST_DELIM: begin
                    if (i_Data == CAN_RECESSIVE) begin
                        if (w_cnt_inc == c_DELIM_END) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end else begin
                        if (i_tx_mode) begin
                            tec_d = w_tec_err;
                        end else begin
                            rec_d = w_rec_err;
                        end
                        state_d        = ST_FLAG;
                        cnt_d          = '0;
                        flag_passive_d = (err_state_q != ERR_ACTIVE);
                    end
                end

                ST_BUSOFF: begin
                    if (w_recover_done) begin
                        tec_d   = 9'd0;
                        rec_d   = 8'd0;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Bus-off preempts any error frame in progress.
        if (tec_d[8]) begin
            state_d = ST_BUSOFF;
            cnt_d   = '0;
        end

        err_frame_d = (state_d == ST_FLAG) || (state_d == ST_DWAIT) || (state_d == ST_DELIM);
        tx_bit_d    = (state_d == ST_FLAG) ? flag_passive_d : CAN_RECESSIVE;
        err_state_d = decode_err_state(tec_d, rec_d, 32'(PASSIVE_LIM));
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q        <= ST_IDLE;
            err_state_q    <= ERR_ACTIVE;
            cnt_q          <= '0;
            tec_q          <= 9'd0;
            rec_q          <= 8'd0;
            flag_passive_q <= 1'b0;
            err_frame_q    <= 1'b0;
            tx_bit_q       <= CAN_RECESSIVE;
        end else begin
            state_q        <= state_d;
            err_state_q    <= err_state_d;
            cnt_q          <= cnt_d;
            tec_q          <= tec_d;
            rec_q          <= rec_d;
            flag_passive_q <= flag_passive_d;
            err_frame_q    <= err_frame_d;
            tx_bit_q       <= tx_bit_d;
        end
    end

    assign o_tec       = tec_q;
    assign o_rec       = rec_q;
    assign o_err_state = err_state_q;
    assign o_err_frame = err_frame_q;
    assign o_tx_bit    = tx_bit_q;

endmodule
`default_nettype wire

// File: tb/tb_can_fault_confinement.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_fault_confinement
//  Description : Directed self-checking bench for can_fault_confinement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_fault_confinement;

    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_FORM  = 5'b10000;
    localparam logic [4:0] E_BIT   = 5'b01000;
    localparam logic [4:0] E_STUFF = 5'b00100;
    localparam logic [4:0] E_CRC   = 5'b00010;
    localparam logic [4:0] E_ACK   = 5'b00001;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_sample_point = 1'b0;
    logic       i_Data = 1'b1;
    logic       i_tx_mode = 1'b0;
    logic       i_form_error = 1'b0;
    logic       i_bit_error = 1'b0;
    logic       i_stuff_error = 1'b0;
    logic       i_crc_error = 1'b0;
    logic       i_ack_error = 1'b0;
    logic       i_frame_ok = 1'b0;
    logic [8:0] o_tec;
    logic [7:0] o_rec;
    logic [1:0] o_err_state;
    logic       o_err_frame;
    logic       o_tx_bit;

    int n_assert = 0;
    int n_fail   = 0;

    can_fault_confinement dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_sample_point (i_sample_point),
        .i_Data         (i_Data),
        .i_tx_mode      (i_tx_mode),
        .i_form_error   (i_form_error),
        .i_bit_error    (i_bit_error),
        .i_stuff_error  (i_stuff_error),
        .i_crc_error    (i_crc_error),
        .i_ack_error    (i_ack_error),
        .i_frame_ok     (i_frame_ok),
        .o_tec          (o_tec),
        .o_rec          (o_rec),
        .o_err_state    (o_err_state),
        .o_err_frame    (o_err_frame),
        .o_tx_bit       (o_tx_bit)
    );

    always #5 i_Clock = ~i_Clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_errs(input logic [4:0] errs);
        {i_form_error, i_bit_error, i_stuff_error, i_crc_error, i_ack_error} = errs;
    endtask

    // One CAN bit: a sample-point cycle, then a quiet cycle.
    task automatic bit_step(input logic data, input logic [4:0] errs, input logic fok);
        i_Data = data;
        set_errs(errs);
        i_frame_ok = fok;
        i_sample_point = 1'b1;
        @(posedge i_Clock); #1;
        i_sample_point = 1'b0;
        set_errs(E_NONE);
        i_frame_ok = 1'b0;
        i_Data = 1'b1;
        @(posedge i_Clock); #1;
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 6; k++) bit_step(1'b0, E_NONE, 1'b0);
        for (int k = 0; k < 8; k++) bit_step(1'b1, E_NONE, 1'b0);
    endtask

    task automatic error_frame(input logic [4:0] errs);
        bit_step(1'b0, errs, 1'b0);
        finish_frame();
    endtask

    task automatic do_reset();
        set_errs(E_NONE);
        i_frame_ok = 1'b0;
        i_sample_point = 1'b0;
        i_Data = 1'b1;
        i_Reset = 1'b1;
        @(posedge i_Clock); @(posedge i_Clock); #1;
        i_Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++; if (o_tec !== 9'd0) begin n_fail++; $display("FAIL reset_tec: got %0d expected 0", o_tec); end
        n_assert++; if (o_rec !== 8'd0) begin n_fail++; $display("FAIL reset_rec: got %0d expected 0", o_rec); end
        n_assert++; if (o_err_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_err_state); end
        n_assert++; if (o_err_frame !== 1'b0) begin n_fail++; $display("FAIL reset_err_frame: got %b expected 0", o_err_frame); end
        n_assert++; if (o_tx_bit !== 1'b1) begin n_fail++; $display("FAIL reset_tx_bit: got %b expected 1", o_tx_bit); end
    endtask

    task automatic test_gating();
        do_reset();
        i_tx_mode = 1'b0;
        i_stuff_error = 1'b1;
        repeat (3) @(posedge i_Clock);
        #1;
        i_stuff_error = 1'b0;
        n_assert++; if (o_rec !== 8'd0) begin n_fail++; $display("FAIL gate_rec: got %0d expected 0", o_rec); end
        n_assert++; if (o_err_frame !== 1'b0) begin n_fail++; $display("FAIL gate_err_frame: got %b expected 0", o_err_frame); end
    endtask

    task automatic test_rx_stuff_error();
        do_reset();
        i_tx_mode = 1'b0;
        bit_step(1'b0, E_STUFF, 1'b0);
        n_assert++; if (o_rec !== 8'd1) begin n_fail++; $display("FAIL rx_rec_inc: got %0d expected 1", o_rec); end
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b10) begin n_fail++; $display("FAIL rx_flag_start: got %b expected 10", {o_err_frame, o_tx_bit}); end
        for (int k = 1; k < 6; k++) begin
            bit_step(1'b0, E_NONE, 1'b0);
            n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b10) begin n_fail++; $display("FAIL rx_flag_bit%0d: got %b expected 10", k, {o_err_frame, o_tx_bit}); end
        end
        bit_step(1'b0, E_NONE, 1'b0);
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b11) begin n_fail++; $display("FAIL rx_dwait: got %b expected 11", {o_err_frame, o_tx_bit}); end
        bit_step(1'b0, E_STUFF, 1'b0);
        n_assert++; if (o_rec !== 8'd1) begin n_fail++; $display("FAIL rx_dwait_err_ignored: got %0d expected 1", o_rec); end
        for (int k = 1; k < 8; k++) begin
            bit_step(1'b1, E_NONE, 1'b0);
            n_assert++; if (o_err_frame !== 1'b1) begin n_fail++; $display("FAIL rx_delim_bit%0d: got %b expected 1", k, o_err_frame); end
        end
        bit_step(1'b1, E_NONE, 1'b0);
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b01) begin n_fail++; $display("FAIL rx_back_idle: got %b expected 01", {o_err_frame, o_tx_bit}); end
        bit_step(1'b0, E_STUFF | E_BIT | E_CRC, 1'b0);
        n_assert++; if (o_rec !== 8'd2) begin n_fail++; $display("FAIL rx_multi_err_one_event: got %0d expected 2", o_rec); end
        finish_frame();
        n_assert++; if (o_err_frame !== 1'b0) begin n_fail++; $display("FAIL rx_multi_frame_end: got %b expected 0", o_err_frame); end
    endtask

    task automatic test_tx_passive();
        do_reset();
        i_tx_mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bit_step(1'b0, E_BIT, 1'b0);
            n_assert++; if (o_tec !== 9'(8 * (k + 1))) begin n_fail++; $display("FAIL tx_tec_step%0d: got %0d expected %0d", k, o_tec, 8 * (k + 1)); end
            n_assert++; if (o_tx_bit !== 1'b0) begin n_fail++; $display("FAIL tx_active_flag%0d: got %b expected 0", k, o_tx_bit); end
            finish_frame();
        end
        n_assert++; if (o_tec !== 9'd128) begin n_fail++; $display("FAIL tx_tec_128: got %0d expected 128", o_tec); end
        n_assert++; if (o_err_state !== 2'd1) begin n_fail++; $display("FAIL tx_passive_state: got %0d expected 1", o_err_state); end
        bit_step(1'b0, E_BIT, 1'b0);
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b11) begin n_fail++; $display("FAIL tx_passive_flag: got %b expected 11", {o_err_frame, o_tx_bit}); end
        n_assert++; if (o_tec !== 9'd136) begin n_fail++; $display("FAIL tx_tec_136: got %0d expected 136", o_tec); end
        bit_step(1'b1, E_BIT, 1'b0);
        n_assert++; if (o_tec !== 9'd136) begin n_fail++; $display("FAIL tx_passive_flag_biterr: got %0d expected 136", o_tec); end
        finish_frame();
        bit_step(1'b1, E_NONE, 1'b1);
        n_assert++; if (o_tec !== 9'd135) begin n_fail++; $display("FAIL tx_frame_ok_dec: got %0d expected 135", o_tec); end
    endtask

    task automatic test_active_flag_bit_error();
        do_reset();
        i_tx_mode = 1'b1;
        bit_step(1'b0, E_FORM, 1'b0);
        n_assert++; if (o_tec !== 9'd8) begin n_fail++; $display("FAIL aflag_first: got %0d expected 8", o_tec); end
        bit_step(1'b0, E_BIT, 1'b0);
        n_assert++; if (o_tec !== 9'd16) begin n_fail++; $display("FAIL aflag_biterr: got %0d expected 16", o_tec); end
        bit_step(1'b0, E_STUFF, 1'b0);
        n_assert++; if (o_tec !== 9'd16) begin n_fail++; $display("FAIL aflag_stuff_ignored: got %0d expected 16", o_tec); end
        finish_frame();
        n_assert++; if (o_err_frame !== 1'b0) begin n_fail++; $display("FAIL aflag_end: got %b expected 0", o_err_frame); end
    endtask

    task automatic test_rec_frame_ok();
        do_reset();
        i_tx_mode = 1'b0;
        for (int k = 0; k < 130; k++) error_frame(E_CRC);
        n_assert++; if (o_rec !== 8'd130) begin n_fail++; $display("FAIL rec_130: got %0d expected 130", o_rec); end
        n_assert++; if (o_err_state !== 2'd1) begin n_fail++; $display("FAIL rec_passive: got %0d expected 1", o_err_state); end
        bit_step(1'b1, E_NONE, 1'b1);
        n_assert++; if (o_rec !== 8'd120) begin n_fail++; $display("FAIL rec_resync: got %0d expected 120", o_rec); end
        n_assert++; if (o_err_state !== 2'd0) begin n_fail++; $display("FAIL rec_back_active: got %0d expected 0", o_err_state); end
        for (int k = 0; k < 119; k++) bit_step(1'b1, E_NONE, 1'b1);
        n_assert++; if (o_rec !== 8'd1) begin n_fail++; $display("FAIL rec_down_to_1: got %0d expected 1", o_rec); end
        bit_step(1'b1, E_NONE, 1'b1);
        n_assert++; if (o_rec !== 8'd0) begin n_fail++; $display("FAIL rec_1_to_0: got %0d expected 0", o_rec); end
        bit_step(1'b1, E_NONE, 1'b1);
        n_assert++; if (o_rec !== 8'd0) begin n_fail++; $display("FAIL rec_0_stays: got %0d expected 0", o_rec); end
    endtask

    task automatic test_busoff_and_recovery();
        do_reset();
        i_tx_mode = 1'b0;
        error_frame(E_ACK);
        i_tx_mode = 1'b1;
        for (int k = 0; k < 31; k++) error_frame(E_FORM);
        n_assert++; if (o_tec !== 9'd248) begin n_fail++; $display("FAIL boff_tec_248: got %0d expected 248", o_tec); end
        bit_step(1'b0, E_FORM, 1'b0);
        n_assert++; if (o_tec !== 9'd256) begin n_fail++; $display("FAIL boff_tec_256: got %0d expected 256", o_tec); end
        n_assert++; if (o_err_state !== 2'd2) begin n_fail++; $display("FAIL boff_state: got %0d expected 2", o_err_state); end
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b01) begin n_fail++; $display("FAIL boff_outputs: got %b expected 01", {o_err_frame, o_tx_bit}); end
        bit_step(1'b0, E_CRC, 1'b1);
        n_assert++; if ({o_tec, o_rec} !== {9'd256, 8'd1}) begin n_fail++; $display("FAIL boff_inputs_ignored: got tec %0d rec %0d expected 256 1", o_tec, o_rec); end
        for (int s = 0; s < 1408; s++) bit_step((s == 64) ? 1'b0 : 1'b1, E_NONE, 1'b0);
        n_assert++; if (o_err_state !== 2'd2) begin n_fail++; $display("FAIL recov_not_yet: got %0d expected 2", o_err_state); end
        for (int s = 0; s < 9; s++) bit_step(1'b1, E_NONE, 1'b0);
        n_assert++; if (o_err_state !== 2'd2) begin n_fail++; $display("FAIL recov_one_short: got %0d expected 2", o_err_state); end
        bit_step(1'b1, E_NONE, 1'b0);
        n_assert++; if ({o_tec, o_rec} !== 17'd0) begin n_fail++; $display("FAIL recov_counters: got tec %0d rec %0d expected 0 0", o_tec, o_rec); end
        n_assert++; if (o_err_state !== 2'd0) begin n_fail++; $display("FAIL recov_state: got %0d expected 0", o_err_state); end
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b01) begin n_fail++; $display("FAIL recov_outputs: got %b expected 01", {o_err_frame, o_tx_bit}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_tx_mode = 1'b1;
        bit_step(1'b0, E_CRC, 1'b1);
        n_assert++; if (o_tec !== 9'd8) begin n_fail++; $display("FAIL simul_err_wins: got %0d expected 8", o_tec); end
        for (int k = 0; k < 6; k++) bit_step(1'b0, E_NONE, 1'b0);
        for (int k = 0; k < 3; k++) bit_step(1'b1, E_NONE, 1'b0);
        bit_step(1'b0, E_NONE, 1'b0);
        n_assert++; if (o_tec !== 9'd16) begin n_fail++; $display("FAIL delim_dom_tec: got %0d expected 16", o_tec); end
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b10) begin n_fail++; $display("FAIL delim_dom_reflag: got %b expected 10", {o_err_frame, o_tx_bit}); end
        finish_frame();
        n_assert++; if (o_err_frame !== 1'b0) begin n_fail++; $display("FAIL reflag_end: got %b expected 0", o_err_frame); end
    endtask

    task automatic test_reset_midflag();
        do_reset();
        i_tx_mode = 1'b1;
        bit_step(1'b0, E_FORM, 1'b0);
        bit_step(1'b0, E_NONE, 1'b0);
        i_Reset = 1'b1;
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
        n_assert++; if (o_tec !== 9'd0) begin n_fail++; $display("FAIL midflag_reset_tec: got %0d expected 0", o_tec); end
        n_assert++; if ({o_err_frame, o_tx_bit} !== 2'b01) begin n_fail++; $display("FAIL midflag_reset_out: got %b expected 01", {o_err_frame, o_tx_bit}); end
    endtask

    initial begin
        test_reset();
        test_gating();
        test_rx_stuff_error();
        test_tx_passive();
        test_active_flag_bit_error();
        test_rec_frame_ok();
        test_busoff_and_recovery();
        test_back_to_back();
        test_reset_midflag();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
